// File: rtl/pc_sequencer_pkg.sv
// Shared constants for the fetch PC sequencer: address width, reset vector
// and FSM state encodings.
package pc_sequencer_pkg;

    localparam int PC_W = 13;
    localparam logic [PC_W-1:0] RESET_PC = 13'h0000;

    localparam logic [1:0] ST_BOOT   = 2'd0;
    localparam logic [1:0] ST_RUN    = 2'd1;
    localparam logic [1:0] ST_HALTED = 2'd2;

endpackage

// File: rtl/pc_sequencer_adder.sv
// 13-bit modulo adder; the sequencer uses it to form the sequential fetch address.
module adder_13bit (
    input  logic [12:0] a,
    input  logic [12:0] b,
    output logic [12:0] sum
);

    assign sum = a + b;

endmodule

// File: rtl/pc_sequencer.sv
// Fetch program counter: chooses sequential / branch / jump next PC, buffers one
// redirect that arrives during a stall, and supports halt/resume.
//
//   state  | meaning
//   BOOT   | single cycle after reset release, pc held, no fetch
//   RUN    | fetching; pc updates whenever stall is low
//   HALTED | pc frozen, redirects ignored until resume
module pc_sequencer #(
    parameter int                PC_W     = pc_sequencer_pkg::PC_W,
    parameter logic [PC_W-1:0]   RESET_PC = pc_sequencer_pkg::RESET_PC
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            branch_taken,
    input  logic [PC_W-1:0] branch_target,
    input  logic            jump,
    input  logic [PC_W-1:0] jump_target,
    input  logic            halt,
    input  logic            resume,
    output logic [PC_W-1:0] pc,
    output logic [PC_W-1:0] pc_plus1,
    output logic            fetch_valid,
    output logic            redirect_pending,
    output logic [1:0]      state
);

    import pc_sequencer_pkg::*;

    logic [1:0]      state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [PC_W-1:0] pend_tgt_q, pend_tgt_d;
    logic            pend_q, pend_d;
    logic            pc_update;

    adder_13bit u_adder (
        .a   (pc_q),
        .b   (13'd1),
        .sum (pc_plus1)
    );

    assign pc_update = (state_q == ST_RUN) && !stall;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_BOOT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_BOOT:   state_d = ST_RUN;
            ST_RUN:    if (halt && !stall) state_d = ST_HALTED;
            ST_HALTED: if (resume && !halt) state_d = ST_RUN;
            default:   state_d = ST_BOOT;
        endcase
    end

    always_comb begin
        fetch_valid = pc_update;
        state       = state_q;
    end

    // A branch in a stall always overwrites the buffer; a jump only fills an empty one.
    always_comb begin
        pc_d       = pc_q;
        pend_d     = pend_q;
        pend_tgt_d = pend_tgt_q;
        if (pc_update) begin
            if (branch_taken)      pc_d = branch_target;
            else if (jump)         pc_d = jump_target;
            else if (pend_q)       pc_d = pend_tgt_q;
            else                   pc_d = pc_plus1;
            pend_d = 1'b0;
        end else if (state_q == ST_RUN) begin
            if (branch_taken) begin
                pend_tgt_d = branch_target;
                pend_d     = 1'b1;
            end else if (jump && !pend_q) begin
                pend_tgt_d = jump_target;
                pend_d     = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q       <= RESET_PC;
            pend_q     <= 1'b0;
            pend_tgt_q <= '0;
        end else begin
            pc_q       <= pc_d;
            pend_q     <= pend_d;
            pend_tgt_q <= pend_tgt_d;
        end
    end

    assign pc               = pc_q;
    assign redirect_pending = pend_q;

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Owns the fetch program counter for the 13-bit word-addressed pipeline.
- Selects the next PC each cycle from three sources: sequential (PC+1), taken branch from EX, and jump from ID.
- Honours pipeline stalls, buffers one redirect that arrives during a stall, and supports halt/resume.
- Sits in front of the instruction memory; its PC+1 result feeds the IF/ID register.

Parameters:
- PC_W, 13, PC width in words.
- RESET_PC, 13'h0000, PC value loaded on reset.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- stall  input  1  hazard unit stall; holds PC
- branch_taken  input  1  EX-stage branch resolved taken
- branch_target  input  PC_W  branch destination
- jump  input  1  ID-stage jump decoded
- jump_target  input  PC_W  jump destination
- halt  input  1  request to stop fetching
- resume  input  1  leave HALTED
- pc  output  PC_W  current fetch address
- pc_plus1  output  PC_W  pc+1 mod 2^PC_W, combinational from pc
- fetch_valid  output  1  instruction at pc is to be fetched
- redirect_pending  output  1  buffered redirect waiting for stall release
- state  output  2  FSM state, for debug

Behaviour:
- Reset (async, active-high) forces:
  - pc=RESET_PC, state=BOOT, fetch_valid=0, redirect_pending=0.
  - Pending target register cleared to 0.
  - Reset asserted mid-operation discards any pending redirect.
- FSM states: BOOT=2'd0, RUN=2'd1, HALTED=2'd2; 2'd3 is illegal and recovers to BOOT.
  - BOOT: lasts exactly one cycle after reset deassertion; pc held; fetch_valid=0; then RUN.
  - RUN: fetch_valid = ~stall.
  - RUN -> HALTED when halt=1 and stall=0. The PC update of that cycle still occurs, so a redirect in the same cycle is applied first, then the FSM halts.
  - HALTED: pc held; fetch_valid=0; redirect inputs ignored. resume=1 -> RUN next cycle. halt and resume both high in HALTED: stay HALTED.
- Next-PC priority in RUN with stall=0:
  1. branch_taken -> branch_target (older instruction wins over jump).
  2. jump -> jump_target.
  3. redirect_pending -> pending target.
  4. Otherwise pc_plus1.
- Stall in RUN (stall=1):
  - pc holds.
  - If branch_taken=1: the pending register takes branch_target and redirect_pending=1, overwriting any pending jump.
  - Else if jump=1 and redirect_pending=0: the pending register takes jump_target.
  - Else the pending register is unchanged.
- Stall release: the first cycle with stall=0 applies the priority list above. redirect_pending clears on any PC update in RUN.
- Wrap-around: pc=13'h1FFF sequential -> 13'h0000. No overflow flag.
- Latency: a redirect presented in cycle N appears on pc in cycle N+1 (unstalled). A buffered redirect appears one cycle after stall release.
- All state updates are on the rising edge of clk; pc_plus1 and fetch_valid are combinational from registered state and stall.

Decomposition:
- Shared package holds:
  - PC_W, RESET_PC.
  - State encodings BOOT/RUN/HALTED as localparams.
- One sub-module: instantiate the existing adder_13bit for pc_plus1. No other submodules; the next-PC mux and FSM are local.

Test Plan:
- Reset, then 4 unstalled cycles: pc 0 held through BOOT; fetch_valid 0 then 1; pc sequence 0,1,2,3.
- Force pc to 13'h1FFE with a jump, then 2 sequential cycles: pc 13'h1FFF then 13'h0000, and pc_plus1 at 13'h1FFF is 0.
- branch_taken=1 (target 13'h0100) and jump=1 (target 13'h0200) in the same cycle: next pc=13'h0100.
- stall=1 for 3 cycles with jump (target 13'h0040) in the first cycle and branch_taken (target 13'h0080) in the second:
  - pc frozen, redirect_pending=1.
  - After release, pc=13'h0080 and redirect_pending=0.
- At pc=5, assert halt with jump to 13'h0010: pc=13'h0010, state=HALTED, fetch_valid=0. Then hold 3 cycles: pc unchanged. Then resume: pc advances to 13'h0011 the cycle after RUN.
- Assert rst mid-stall with redirect_pending=1: pc=0 and redirect_pending=0 immediately, without a clock edge; BOOT for one cycle after release.
